// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port 32x8 RAM: IDLE -> ISSUE -> (CAPTURE) -> IDLE.
// Define ARB_RR_EN for round-robin arbitration; otherwise port A has fixed priority.
module mem_arbiter (
  input  logic       CLOCK,
  input  logic       RESET,
  input  logic       A_REQ,
  input  logic       A_WE,
  input  logic [4:0] A_ADDR,
  input  logic [7:0] A_D,
  input  logic       B_REQ,
  input  logic       B_WE,
  input  logic [4:0] B_ADDR,
  input  logic [7:0] B_D,
  output logic       A_GNT,
  output logic       B_GNT,
  output logic       A_VALID,
  output logic       B_VALID,
  output logic [7:0] A_Q,
  output logic [7:0] B_Q,
  output logic [4:0] MEM_ADDR,
  output logic [7:0] MEM_D,
  output logic       MEM_WE,
  input  logic [7:0] MEM_Q,
  output logic       BUSY
);

  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    ISSUE   = 2'b01,
    CAPTURE = 2'b10
  } state_t;

  state_t      state_q, state_d;
  logic        win_b_q, win_b_d;
  logic        a_gnt_q, a_gnt_d, b_gnt_q, b_gnt_d;
  logic        a_valid_q, a_valid_d, b_valid_q, b_valid_d;
  logic [7:0]  a_q_q, a_q_d, b_q_q, b_q_d;
  logic [4:0]  mem_addr_q, mem_addr_d;
  logic [7:0]  mem_d_q, mem_d_d;
  logic        mem_we_q, mem_we_d;
  logic        busy_q, busy_d;
  logic        pick_b;

`ifdef ARB_RR_EN
  logic        last_b_q, last_b_d;
  // On a tie the port that was not granted last wins.
  assign pick_b = B_REQ && (!A_REQ || !last_b_q);
`else
  assign pick_b = B_REQ && !A_REQ;
`endif

  always_comb begin
    state_d    = state_q;
    win_b_d    = win_b_q;
    a_gnt_d    = 1'b0;
    b_gnt_d    = 1'b0;
    a_valid_d  = 1'b0;
    b_valid_d  = 1'b0;
    a_q_d      = a_q_q;
    b_q_d      = b_q_q;
    mem_addr_d = mem_addr_q;
    mem_d_d    = mem_d_q;
    mem_we_d   = 1'b0;
`ifdef ARB_RR_EN
    last_b_d   = last_b_q;
`endif
    case (state_q)
      IDLE: begin
        if (A_REQ || B_REQ) begin
          win_b_d    = pick_b;
          a_gnt_d    = !pick_b;
          b_gnt_d    = pick_b;
          mem_addr_d = pick_b ? B_ADDR : A_ADDR;
          mem_d_d    = pick_b ? B_D : A_D;
          mem_we_d   = pick_b ? B_WE : A_WE;
`ifdef ARB_RR_EN
          last_b_d   = pick_b;
`endif
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        // mem_we_q still holds the captured write flag during this cycle.
        if (mem_we_q) begin
          a_valid_d = !win_b_q;
          b_valid_d = win_b_q;
          state_d   = IDLE;
        end else begin
          state_d   = CAPTURE;
        end
      end
      CAPTURE: begin
        if (win_b_q) b_q_d = MEM_Q;
        else         a_q_d = MEM_Q;
        a_valid_d = !win_b_q;
        b_valid_d = win_b_q;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      state_q    <= IDLE;
      win_b_q    <= 1'b0;
      a_gnt_q    <= 1'b0;
      b_gnt_q    <= 1'b0;
      a_valid_q  <= 1'b0;
      b_valid_q  <= 1'b0;
      a_q_q      <= 8'h00;
      b_q_q      <= 8'h00;
      mem_addr_q <= 5'h00;
      mem_d_q    <= 8'h00;
      mem_we_q   <= 1'b0;
      busy_q     <= 1'b0;
`ifdef ARB_RR_EN
      last_b_q   <= 1'b1;
`endif
    end else begin
      state_q    <= state_d;
      win_b_q    <= win_b_d;
      a_gnt_q    <= a_gnt_d;
      b_gnt_q    <= b_gnt_d;
      a_valid_q  <= a_valid_d;
      b_valid_q  <= b_valid_d;
      a_q_q      <= a_q_d;
      b_q_q      <= b_q_d;
      mem_addr_q <= mem_addr_d;
      mem_d_q    <= mem_d_d;
      mem_we_q   <= mem_we_d;
      busy_q     <= busy_d;
`ifdef ARB_RR_EN
      last_b_q   <= last_b_d;
`endif
    end
  end

  assign A_GNT    = a_gnt_q;
  assign B_GNT    = b_gnt_q;
  assign A_VALID  = a_valid_q;
  assign B_VALID  = b_valid_q;
  assign A_Q      = a_q_q;
  assign B_Q      = b_q_q;
  assign MEM_ADDR = mem_addr_q;
  assign MEM_D    = mem_d_q;
  assign MEM_WE   = mem_we_q;
  assign BUSY     = busy_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, directed corner sequences and a random run
// checked against a transaction-level model of the arbiter and RAM.
module tb_mem_arbiter;

`ifdef ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic       CLOCK = 1'b0;
  logic       RESET = 1'b1;
  logic       A_REQ = 1'b0, A_WE = 1'b0, B_REQ = 1'b0, B_WE = 1'b0;
  logic [4:0] A_ADDR = 5'h00, B_ADDR = 5'h00;
  logic [7:0] A_D = 8'h00, B_D = 8'h00;
  logic       A_GNT, B_GNT, A_VALID, B_VALID, MEM_WE, BUSY;
  logic [7:0] A_Q, B_Q, MEM_D;
  logic [4:0] MEM_ADDR;
  logic [7:0] MEM_Q = 8'h00;

  logic [7:0] tb_ram [32] = '{default: 8'h00};

  int n_err = 0;
  int n_chk = 0;

  mem_arbiter dut (
    .CLOCK(CLOCK), .RESET(RESET),
    .A_REQ(A_REQ), .A_WE(A_WE), .A_ADDR(A_ADDR), .A_D(A_D),
    .B_REQ(B_REQ), .B_WE(B_WE), .B_ADDR(B_ADDR), .B_D(B_D),
    .A_GNT(A_GNT), .B_GNT(B_GNT), .A_VALID(A_VALID), .B_VALID(B_VALID),
    .A_Q(A_Q), .B_Q(B_Q),
    .MEM_ADDR(MEM_ADDR), .MEM_D(MEM_D), .MEM_WE(MEM_WE), .MEM_Q(MEM_Q),
    .BUSY(BUSY)
  );

  always #5 CLOCK = ~CLOCK;

  // External RAM with registered read.
  always @(posedge CLOCK) begin
    if (MEM_WE) tb_ram[MEM_ADDR] <= MEM_D;
    MEM_Q <= tb_ram[MEM_ADDR];
  end

  // Transaction-level reference model.
  logic [7:0] ram_m [32] = '{default: 8'h00};
  bit         last_b_m = 1'b1;
  logic [7:0] exp_aq = 8'h00, exp_bq = 8'h00;

  function automatic void model_reset();
    last_b_m = 1'b1;
    exp_aq   = 8'h00;
    exp_bq   = 8'h00;
  endfunction

  function automatic void model_apply(input int port, input logic we,
                                      input logic [4:0] addr, input logic [7:0] d);
    if (we) ram_m[addr] = d;
    else if (port == 0) exp_aq = ram_m[addr];
    else exp_bq = ram_m[addr];
    last_b_m = (port == 1);
  endfunction

  function automatic int model_pair(input logic ar, aw, input logic [4:0] aa, input logic [7:0] ad,
                                    input logic br, bw, input logic [4:0] ba, input logic [7:0] bd);
    int first;
    if (ar && br) first = RR ? (last_b_m ? 0 : 1) : 0;
    else          first = ar ? 0 : 1;
    if (first == 0) begin
      model_apply(0, aw, aa, ad);
      if (br) model_apply(1, bw, ba, bd);
    end else begin
      model_apply(1, bw, ba, bd);
      if (ar) model_apply(0, aw, aa, ad);
    end
    return first;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    A_REQ = 1'b0;
    B_REQ = 1'b0;
    @(posedge CLOCK); #1;
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    model_reset();
  endtask

  // Drives one or two simultaneous requests and follows them to completion.
  task automatic run_pair(input logic ar, aw, input logic [4:0] aa, input logic [7:0] ad,
                          input logic br, bw, input logic [4:0] ba, input logic [7:0] bd,
                          output int first);
    int ga, gb, va, vb, na_g, nb_g, na_v, nb_v, we_cnt, overlap;
    ga = -1; gb = -1; va = -1; vb = -1;
    na_g = 0; nb_g = 0; na_v = 0; nb_v = 0; we_cnt = 0; overlap = 0; first = -1;
    A_REQ = ar; A_WE = aw; A_ADDR = aa; A_D = ad;
    B_REQ = br; B_WE = bw; B_ADDR = ba; B_D = bd;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(posedge CLOCK); #1;
      if (MEM_WE) we_cnt++;
      if (A_GNT && B_GNT) overlap++;
      if (A_GNT) begin
        na_g++; ga = cyc; A_REQ = 1'b0;
        if (first < 0) first = 0;
        chk("gnt_mem_addr_a", int'(MEM_ADDR), int'(aa));
        chk("gnt_mem_we_a", int'(MEM_WE), int'(aw));
        if (aw) chk("gnt_mem_d_a", int'(MEM_D), int'(ad));
        chk("gnt_busy_a", int'(BUSY), 1);
      end
      if (B_GNT) begin
        nb_g++; gb = cyc; B_REQ = 1'b0;
        if (first < 0) first = 1;
        chk("gnt_mem_addr_b", int'(MEM_ADDR), int'(ba));
        chk("gnt_mem_we_b", int'(MEM_WE), int'(bw));
        if (bw) chk("gnt_mem_d_b", int'(MEM_D), int'(bd));
        chk("gnt_busy_b", int'(BUSY), 1);
      end
      if (A_VALID) begin na_v++; va = cyc; end
      if (B_VALID) begin nb_v++; vb = cyc; end
      if ((!ar || na_v > 0) && (!br || nb_v > 0)) break;
    end
    A_REQ = 1'b0;
    B_REQ = 1'b0;
    chk("gnt_overlap", overlap, 0);
    chk("a_gnt_count", na_g, ar ? 1 : 0);
    chk("b_gnt_count", nb_g, br ? 1 : 0);
    chk("a_valid_count", na_v, ar ? 1 : 0);
    chk("b_valid_count", nb_v, br ? 1 : 0);
    chk("mem_we_pulses", we_cnt, int'(ar && aw) + int'(br && bw));
    if (ar) chk("a_latency", va - ga, aw ? 1 : 2);
    if (br) chk("b_latency", vb - gb, bw ? 1 : 2);
    chk("first_gnt_cycle", (first == 1) ? gb : ga, 1);
    if (ar && br) begin
      if (first == 0) chk("second_gnt_cycle", gb, va + 1);
      else            chk("second_gnt_cycle", ga, vb + 1);
    end
    $display("txn A(req=%b we=%b addr=%h d=%h) B(req=%b we=%b addr=%h d=%h) first=%0d A_Q=%h B_Q=%h",
             ar, aw, aa, ad, br, bw, ba, bd, first, A_Q, B_Q);
  endtask

  typedef struct {
    logic       ar, aw;
    logic [4:0] aa;
    logic [7:0] ad;
    logic       br, bw;
    logic [4:0] ba;
    logic [7:0] bd;
    int         exp_first;
    logic [7:0] exp_aq, exp_bq;
  } vec_t;

  localparam int NV = 10;
  vec_t vecs [NV];

  initial begin
    int df, mf, ng, nb, nv, seen, exp_p;
    logic ar, aw, br, bw;
    logic [4:0] aa, ba;
    logic [7:0] ad, bd;

    vecs[0] = '{1'b1, 1'b1, 5'h03, 8'hA5, 1'b0, 1'b0, 5'h00, 8'h00, 0, 8'h00, 8'h00};
    vecs[1] = '{1'b1, 1'b0, 5'h03, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, 0, 8'hA5, 8'h00};
    vecs[2] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 5'h00, 8'h3C, 1, 8'hA5, 8'h00};
    vecs[3] = '{1'b1, 1'b0, 5'h00, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, 0, 8'h3C, 8'h00};
    vecs[4] = '{1'b1, 1'b1, 5'h01, 8'hC3, 1'b0, 1'b0, 5'h00, 8'h00, 0, 8'h3C, 8'h00};
    vecs[5] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b1, 5'h02, 8'h5A, 1, 8'h3C, 8'h00};
    vecs[6] = '{1'b1, 1'b0, 5'h01, 8'h00, 1'b1, 1'b0, 5'h02, 8'h00, 0, 8'hC3, 8'h5A};
    vecs[7] = '{1'b1, 1'b1, 5'h04, 8'h11, 1'b1, 1'b1, 5'h04, 8'h22, 0, 8'hC3, 8'h5A};
    vecs[8] = '{1'b1, 1'b0, 5'h04, 8'h00, 1'b0, 1'b0, 5'h00, 8'h00, 0, 8'h22, 8'h5A};
    vecs[9] = '{1'b0, 1'b0, 5'h00, 8'h00, 1'b1, 1'b0, 5'h03, 8'h00, 1, 8'h22, 8'hA5};

    // Reset values while RESET is held.
    @(posedge CLOCK); #1;
    chk("rst_gnt", int'({A_GNT, B_GNT}), 0);
    chk("rst_valid", int'({A_VALID, B_VALID}), 0);
    chk("rst_a_q", int'(A_Q), 0);
    chk("rst_b_q", int'(B_Q), 0);
    chk("rst_mem_addr", int'(MEM_ADDR), 0);
    chk("rst_mem_d", int'(MEM_D), 0);
    chk("rst_mem_we", int'(MEM_WE), 0);
    chk("rst_busy", int'(BUSY), 0);
    do_reset();

    for (int i = 0; i < NV; i++) begin
      mf = model_pair(vecs[i].ar, vecs[i].aw, vecs[i].aa, vecs[i].ad,
                      vecs[i].br, vecs[i].bw, vecs[i].ba, vecs[i].bd);
      run_pair(vecs[i].ar, vecs[i].aw, vecs[i].aa, vecs[i].ad,
               vecs[i].br, vecs[i].bw, vecs[i].ba, vecs[i].bd, df);
      chk($sformatf("vec%0d_first", i), df, vecs[i].exp_first);
      chk($sformatf("vec%0d_a_q", i), int'(A_Q), int'(vecs[i].exp_aq));
      chk($sformatf("vec%0d_b_q", i), int'(B_Q), int'(vecs[i].exp_bq));
    end

    // Both requests held for four grants.
    do_reset();
    A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 5'h01;
    B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 5'h02;
    ng = 0;
    for (int c = 0; c < 40 && ng < 4; c++) begin
      @(posedge CLOCK); #1;
      if (A_GNT || B_GNT) begin
        exp_p = RR ? (last_b_m ? 0 : 1) : 0;
        model_apply(exp_p, 1'b0, (exp_p == 0) ? 5'h01 : 5'h02, 8'h00);
        chk($sformatf("hold_grant%0d_port", ng), B_GNT ? 1 : 0, exp_p);
        $display("txn hold grant %0d: A_GNT=%b B_GNT=%b", ng, A_GNT, B_GNT);
        ng++;
      end
    end
    A_REQ = 1'b0;
    B_REQ = 1'b0;
    chk("hold_grants", ng, 4);
    for (int c = 0; c < 10; c++) begin
      @(posedge CLOCK); #1;
      if (!BUSY) break;
    end
    chk("hold_idle", int'(BUSY), 0);
    chk("hold_a_q", int'(A_Q), int'(exp_aq));
    chk("hold_b_q", int'(B_Q), int'(exp_bq));

    // Reset during the ISSUE cycle of a write aborts it.
    do_reset();
    A_REQ = 1'b1; A_WE = 1'b1; A_ADDR = 5'h1F; A_D = 8'hFF;
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLOCK); #1;
      if (A_GNT) begin seen = 1; break; end
    end
    chk("abort_gnt_seen", seen, 1);
    chk("abort_we_before", int'(MEM_WE), 1);
    RESET = 1'b1;
    A_REQ = 1'b0;
    #1;
    chk("abort_we_async", int'(MEM_WE), 0);
    chk("abort_busy", int'(BUSY), 0);
    chk("abort_gnt", int'(A_GNT), 0);
    @(posedge CLOCK); #1;
    RESET = 1'b0;
    model_reset();
    nv = 0;
    for (int c = 0; c < 4; c++) begin
      @(posedge CLOCK); #1;
      if (A_VALID || B_VALID) nv++;
    end
    chk("abort_no_valid", nv, 0);
    chk("abort_ram31", int'(tb_ram[31]), int'(ram_m[31]));
    $display("txn abort write 1f: RAM[31]=%h", tb_ram[31]);

    // B pulses its request only while A's read is in CAPTURE.
    A_REQ = 1'b1; A_WE = 1'b0; A_ADDR = 5'h03;
    model_apply(0, 1'b0, 5'h03, 8'h00);
    seen = 0;
    for (int c = 0; c < 5; c++) begin
      @(posedge CLOCK); #1;
      if (A_GNT) begin seen = 1; break; end
    end
    A_REQ = 1'b0;
    chk("pulse_a_gnt", seen, 1);
    @(posedge CLOCK); #1;
    chk("pulse_cap_busy", int'(BUSY), 1);
    chk("pulse_cap_no_valid", int'(A_VALID), 0);
    B_REQ = 1'b1; B_WE = 1'b0; B_ADDR = 5'h02;
    nb = 0;
    @(posedge CLOCK); #1;
    chk("pulse_a_valid", int'(A_VALID), 1);
    if (B_GNT) nb++;
    B_REQ = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLOCK); #1;
      if (B_GNT) nb++;
    end
    chk("pulse_no_b_gnt", nb, 0);
    chk("pulse_a_q", int'(A_Q), int'(exp_aq));
    chk("pulse_b_q", int'(B_Q), int'(exp_bq));
    $display("txn pulse: A_Q=%h B_GNT count=%0d", A_Q, nb);

    // Random pairs against the model.
    for (int i = 0; i < 60; i++) begin
      ar = 1'($urandom_range(0, 1));
      br = 1'($urandom_range(0, 1));
      if (!ar && !br) ar = 1'b1;
      aw = 1'($urandom_range(0, 1));
      bw = 1'($urandom_range(0, 1));
      aa = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ba = ($urandom_range(0, 1) == 1) ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
      ad = 8'($urandom_range(0, 255));
      bd = 8'($urandom_range(0, 255));
      mf = model_pair(ar, aw, aa, ad, br, bw, ba, bd);
      run_pair(ar, aw, aa, ad, br, bw, ba, bd, df);
      chk("rand_first", df, mf);
      chk("rand_a_q", int'(A_Q), int'(exp_aq));
      chk("rand_b_q", int'(B_Q), int'(exp_bq));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
